norm_mult_controller_p: RTL
===========================

Name: norm_mult_controller_p

Overview:
- Parametrised controller for the normalise–multiply–denormalise datapath. It is the next generation of the fixed 7-state shift controller.
- Adds configurable operand width and multiplier latency, an internal shift counter that counts two per cycle, and a zero-operand early exit.
- Sits beside the operand shift registers, the truncated multiplier and the result shift register. It drives only their enables and selects; it has no data path.

Parameters:
- DATA_W, 8, operand width in bits (>=4).
- MULT_LAT, 2, multiplier latency in cycles (>=1).
- CNT_W, $clog2(2*DATA_W), width of the shift counter.
- LAT_W, $clog2(MULT_LAT+1), width of the latency counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request level from host.
- zero_a  in  1  operand A register is all zeros.
- zero_b  in  1  operand B register is all zeros.
- msb_a  in  1  operand A MSB is 1 (A is normalised).
- msb_b  in  1  operand B MSB is 1 (B is normalised).
- load_ops  out  1  load both operand registers.
- sh_a_en  out  1  left-shift operand A.
- sh_b_en  out  1  left-shift operand B.
- mult_en  out  1  multiplier enable.
- load_res  out  1  load result register.
- sel_res  out  1  result-register input mux selects the multiplier output.
- sh_res_en  out  1  right-shift the result register.
- clr_res  out  1  synchronous clear of the result register.
- shift_cnt  out  CNT_W  current shift counter value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- State is one-hot, 9 states: IDLE, ARM, LOAD, NORM, MULT, LDRES, DENORM, ZERO, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE, shift_cnt=0, latency counter=0.
  - All outputs are 0.
  - Reset asserted mid-operation aborts immediately; no done pulse is issued.
- IDLE: when start=1, go to ARM.
- ARM: wait for start=0, then go to LOAD. This is a start-release handshake; holding start high stalls in ARM.
- LOAD: load_ops=1, shift_cnt<=0. Next state is NORM.
- NORM, evaluated each cycle with priority:
  - If zero_a or zero_b: go to ZERO.
  - Else if msb_a and msb_b: go to MULT and set latency counter <= MULT_LAT-1.
  - Else: sh_a_en=!msb_a, sh_b_en=!msb_b, shift_cnt += (!msb_a)+(!msb_b), stay in NORM.
- Saturation guard: if shift_cnt would reach or exceed 2*(DATA_W-1), go to MULT anyway. This protects against a faulty datapath.
- MULT: mult_en=1. Decrement the latency counter; when it is 0, go to LDRES.
- LDRES: load_res=1, sel_res=1 for one cycle. If shift_cnt==0, go to DONE; otherwise go to DENORM.
- DENORM: sh_res_en=1, shift_cnt -= 1 each cycle. In the cycle where shift_cnt==1, the next state is DONE. Underflow is impossible by construction.
- ZERO: clr_res=1 for one cycle. shift_cnt is left unchanged. Next state is DONE.
- DONE: done=1 for one cycle. Next state is IDLE.
- start is ignored in every state except IDLE and ARM.
- All outputs are Moore, decoded from the state register, except sh_a_en and sh_b_en, which also depend on msb_a and msb_b.
- Latency from the first LOAD cycle to done, where na and nb are the shifts A and B need:
  - Normal path: 1 + (max(na,nb)+1) + MULT_LAT + 1 + (na+nb) cycles, with done in the following cycle.
  - Zero path: done 3 cycles after LOAD.

Decomposition:
- Package norm_mult_pkg holds:
  - one-hot state localparams (index constants ST_IDLE..ST_DONE);
  - the function cnt_width(DATA_W).
- One sub-module, shift_count_reg, holds the CNT_W up/down counter, with:
  - synchronous clear;
  - increment by 0, 1 or 2;
  - decrement by 1;
  - the asynchronous active-low reset.
- The FSM next-state logic and output decode stay in the top module.

Test Plan:
- Reset mid-DENORM, with rst=0 for 1 cycle → state IDLE at once; shift_cnt=0; all outputs 0; no done pulse.
- DATA_W=8, MULT_LAT=2, A=0x10 (na=3), B=0x40 (nb=1), start high 1 cycle then low → cycle timing:
  - LOAD cycle 1;
  - NORM cycles 2–5, with sh_a_en 1,1,1,0 and sh_b_en 1,0,0,0;
  - shift_cnt reaches 4;
  - MULT cycles 6–7;
  - LDRES cycle 8;
  - DENORM cycles 9–12, shift_cnt counting 4→0;
  - done in cycle 13; busy low in cycle 14.
- A=0x80, B=0xFF (both already normalised) → NORM lasts 1 cycle; LDRES goes straight to DONE with no sh_res_en; done 5 cycles after LOAD.
- A=0x00, B=0x35 → the first NORM cycle goes to ZERO; clr_res pulses once; done in cycle 4; mult_en never asserted.
- start held high for 5 cycles → stays in ARM with load_ops=0 until start falls, then LOAD. A start pulse during DENORM has no effect on timing.
- DATA_W=16, MULT_LAT=4, A=0x0001, B=0x0001 → shift_cnt=30; 15 NORM shift cycles; 4 mult_en cycles; 30 sh_res_en cycles; exactly one done pulse.

Source files
------------

// File: rtl/norm_mult_pkg.sv
// Shared constants for the normalise-multiply-denormalise controller:
// one-hot state indices/encodings and the shift-counter width helper.
package norm_mult_pkg;

  localparam int NUM_ST    = 9;
  localparam int ST_IDLE   = 0;
  localparam int ST_ARM    = 1;
  localparam int ST_LOAD   = 2;
  localparam int ST_NORM   = 3;
  localparam int ST_MULT   = 4;
  localparam int ST_LDRES  = 5;
  localparam int ST_DENORM = 6;
  localparam int ST_ZERO   = 7;
  localparam int ST_DONE   = 8;

  typedef enum logic [NUM_ST-1:0] {
    S_IDLE   = 9'b0_0000_0001,
    S_ARM    = 9'b0_0000_0010,
    S_LOAD   = 9'b0_0000_0100,
    S_NORM   = 9'b0_0000_1000,
    S_MULT   = 9'b0_0001_0000,
    S_LDRES  = 9'b0_0010_0000,
    S_DENORM = 9'b0_0100_0000,
    S_ZERO   = 9'b0_1000_0000,
    S_DONE   = 9'b1_0000_0000
  } state_t;

  // Counter must hold the combined shift of both operands, up to 2*(DATA_W-1).
  function automatic int cnt_width(input int data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/norm_mult_controller_p_shift_count_reg.sv
// Up/down shift counter: clear wins over decrement, decrement wins over
// increment (increment step 0..2).
module shift_count_reg #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [1:0]       i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(i_inc);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/norm_mult_controller_p.sv
// Control FSM for the normalise-multiply-denormalise datapath: drives only
// enables/selects of the operand, multiplier and result registers.
module norm_mult_controller_p
  import norm_mult_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = cnt_width(DATA_W),
  parameter int LAT_W    = $clog2(MULT_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             zero_a,
  input  logic             zero_b,
  input  logic             msb_a,
  input  logic             msb_b,
  output logic             load_ops,
  output logic             sh_a_en,
  output logic             sh_b_en,
  output logic             mult_en,
  output logic             load_res,
  output logic             sel_res,
  output logic             sh_res_en,
  output logic             clr_res,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             busy,
  output logic             done
);

  localparam int CW1     = CNT_W + 1;
  localparam int SAT_LIM = 2 * (DATA_W - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [LAT_W-1:0] r_lat;

  logic             w_any_zero;
  logic             w_both_norm;
  logic             w_shift;
  logic             w_sat;
  logic [1:0]       w_inc;
  logic [CW1-1:0]   w_cnt_sum;

  logic r_load_ops, r_mult_en, r_load_res, r_sel_res;
  logic r_sh_res_en, r_clr_res, r_busy, r_done;

  assign w_any_zero  = zero_a | zero_b;
  assign w_both_norm = msb_a & msb_b;
  assign w_shift     = (r_state == S_NORM) & ~w_any_zero & ~w_both_norm;
  assign sh_a_en     = w_shift & ~msb_a;
  assign sh_b_en     = w_shift & ~msb_b;
  assign w_inc       = {1'b0, sh_a_en} + {1'b0, sh_b_en};

  // A healthy datapath never reaches the limit; this only bounds a stuck one.
  assign w_cnt_sum   = {1'b0, shift_cnt} + CW1'(w_inc);
  assign w_sat       = w_cnt_sum >= CW1'(SAT_LIM);

  shift_count_reg #(
    .CNT_W (CNT_W)
  ) u_shift_count_reg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == S_LOAD),
    .i_inc (w_inc),
    .i_dec (r_state == S_DENORM),
    .o_cnt (shift_cnt)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_ARM;
      S_ARM:    if (!start) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_NORM;
      S_NORM: begin
        if (w_any_zero)                w_state_next = S_ZERO;
        else if (w_both_norm || w_sat) w_state_next = S_MULT;
      end
      S_MULT:   if (r_lat == '0) w_state_next = S_LDRES;
      S_LDRES:  w_state_next = (shift_cnt == '0) ? S_DONE : S_DENORM;
      S_DENORM: if (shift_cnt == CNT_W'(1)) w_state_next = S_DONE;
      S_ZERO:   w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_load_ops  <= 1'b0;
      r_mult_en   <= 1'b0;
      r_load_res  <= 1'b0;
      r_sel_res   <= 1'b0;
      r_sh_res_en <= 1'b0;
      r_clr_res   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_NORM && w_state_next == S_MULT) begin
        r_lat <= LAT_W'(MULT_LAT - 1);
      end else if (r_state == S_MULT && r_lat != '0) begin
        r_lat <= r_lat - LAT_W'(1);
      end
      r_load_ops  <= (w_state_next == S_LOAD);
      r_mult_en   <= (w_state_next == S_MULT);
      r_load_res  <= (w_state_next == S_LDRES);
      r_sel_res   <= (w_state_next == S_LDRES);
      r_sh_res_en <= (w_state_next == S_DENORM);
      r_clr_res   <= (w_state_next == S_ZERO);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_DONE);
    end
  end

  assign load_ops  = r_load_ops;
  assign mult_en   = r_mult_en;
  assign load_res  = r_load_res;
  assign sel_res   = r_sel_res;
  assign sh_res_en = r_sh_res_en;
  assign clr_res   = r_clr_res;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
